pe_tap_sequencer: RTL
=====================

# pe_tap_sequencer

Drives a single Q7.8 processing element (PE) to compute a 1-D valid convolution, one tap at a time. The PE holds one registered weight and does a combinational multiply-accumulate, so this block acts as the initiator side of that PE interface. It buffers a filter row and an image row, and for each output position:
- loads each weight into the PE,
- presents the matching image sample with the running partial sum,
- captures the PE result.

Completed outputs leave through a valid/ready stream. It sits between the row buffers/host loader and one PE.

## Interface
- K_MAX, 8, maximum filter taps (weight buffer depth)
- N_MAX, 32, maximum image row length (image buffer depth)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- cfg_k  in  $clog2(K_MAX+1)  tap count, sampled at start
- cfg_n  in  $clog2(N_MAX+1)  image length, sampled at start
- wgt_wr_en / wgt_wr_addr / wgt_wr_data  in  1 / $clog2(K_MAX) / 16  weight buffer write, signed Q7.8
- img_wr_en / img_wr_addr / img_wr_data  in  1 / $clog2(N_MAX) / 16  image buffer write, signed Q7.8
- start  in  1  begin a run (level sampled in IDLE)
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of run
- cfg_err  out  1  one-cycle pulse with done when config invalid
- pe_weight_val / pe_weight_en  out  16 / 1  to PE weight register
- pe_image_val / pe_image_en  out  16 / 1  to PE image input
- pe_psum_in  out  16  running partial sum to PE
- pe_psum_out  in  16  PE result
- out_valid / out_ready / out_data  out / in / out  1 / 1 / 16  result stream, signed Q7.8

## Operation
- FSM states:
  - IDLE: on start → LOAD_W if config valid, else DONE with cfg_err=1.
  - LOAD_W: pe_weight_en=1, pe_weight_val=wbuf[k] → MAC.
  - MAC: pe_image_en=1, pe_image_val=ibuf[i+k], pe_psum_in=acc; acc←pe_psum_out at edge; if k==cfg_k-1 → EMIT, else k++ → LOAD_W.
  - EMIT: out_valid=1, out_data=acc; on out_ready: if i==cfg_n-cfg_k → DONE, else i++, k←0, acc←0 → LOAD_W.
  - DONE: done=1 → IDLE.
- Config is valid iff 1≤cfg_k≤K_MAX, cfg_k≤cfg_n≤N_MAX. cfg_k/cfg_n latch at start; later changes have no effect on the run.
- The run produces cfg_n−cfg_k+1 outputs in index order. acc clears to 0 at start of every output.
- All arithmetic and saturation are done by the PE; this block never modifies pe_psum_out.
- Buffer writes are accepted only in IDLE; writes while busy are dropped. start while busy is ignored.
- Outside their active state, pe_weight_en, pe_image_en, pe_weight_val, pe_image_val and pe_psum_in are 0.

## Timing
- Reset (any time, including mid-run): state IDLE, acc/i/k=0, every output 0. Buffer contents are undefined after reset; reload them.
- start sampled at edge 0 → LOAD_W for tap 0 in cycle 1.
- Each tap takes 2 cycles. out_valid rises in cycle 2·cfg_k+1 after the start edge.
- out_valid/out_data hold stable until out_ready. The transfer occurs on the edge where both are high; the next LOAD_W starts the following cycle.
- With out_ready held high, each output costs 2·cfg_k+1 cycles. done follows 1 cycle after the last transfer.
- Invalid config: done and cfg_err are high in cycle 1. No PE or stream activity.

## Configuration
- PE_TAP_SEQ_SKIP_ZERO_EN defined: in LOAD_W, a tap with wbuf[k]==0 skips both its LOAD_W and MAC cycles (k advances, acc unchanged, PE enables stay 0). If every tap is zero, the block goes straight to EMIT with acc=0.
- Undefined: every tap always takes 2 cycles. Cycle counts are fixed at 2·cfg_k+1 per output.

## Structure
- Shared package pe_pkg:
  - q78_t (logic signed [15:0]),
  - state enum pe_seq_state_t {IDLE, LOAD_W, MAC, EMIT, DONE},
  - Q78_ONE = 16'sd256.
- One sub-module, pe_row_buf: parameterized-depth register file, synchronous write, combinational read. Instantiated twice (weights, image).
- Top level holds the FSM, counters and acc.

## Test plan
- Taps K=3, weights {256,512,−256}, image N=4 {256,512,768,1024}, driving the team PE, out_ready=1 → outputs 512 then 1024; out_valid in cycles 7 and 14; done in cycle 15.
- Same run with out_ready low for 5 cycles at the first output → out_data holds 512 throughout; no PE enables while stalled; second output still 1024.
- cfg_k=5, cfg_n=4 → done and cfg_err pulse in cycle 1; no out_valid; no PE enable ever high.
- rst asserted during MAC of output 1 → all outputs 0 immediately; the next start with the same buffers reloaded reproduces 512, 1024.
- K=1, weight 256, N=3 {−256, 0, 32767} → outputs −256, 0, 32767; 3 cycles each.
- With PE_TAP_SEQ_SKIP_ZERO_EN, weights {256,0,−256} on image {256,512,768,1024} → outputs −512, −512; out_valid in cycle 5; exactly 2 pe_weight_en pulses per output.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types for the Q7.8 processing-element sequencer: sample type,
// sequencer state encoding and the Q7.8 unity constant.
package pe_pkg;

   typedef logic signed [15:0] q78_t;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      MAC,
      EMIT,
      DONE
   } pe_seq_state_t;

   localparam q78_t Q78_ONE = 16'sd256;

endpackage

// File: rtl/pe_row_buf.sv
// Row buffer: parameterized-depth register file of Q7.8 samples,
// synchronous write, combinational read. Contents are not reset.
module pe_row_buf
   import pe_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [15:0]   wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [15:0]   rd_data
);

   q78_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pe_tap_sequencer.sv
// Tap sequencer driving one Q7.8 PE through a 1-D valid convolution.
// Optional PE_TAP_SEQ_SKIP_ZERO_EN: zero-valued taps cost no cycles.
module pe_tap_sequencer
   import pe_pkg::*;
#(
   parameter int unsigned K_MAX = 8,
   parameter int unsigned N_MAX = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [$clog2(K_MAX+1)-1:0] cfg_k,
   input  logic [$clog2(N_MAX+1)-1:0] cfg_n,
   input  logic                       wgt_wr_en,
   input  logic [$clog2(K_MAX)-1:0]   wgt_wr_addr,
   input  logic [15:0]                wgt_wr_data,
   input  logic                       img_wr_en,
   input  logic [$clog2(N_MAX)-1:0]   img_wr_addr,
   input  logic [15:0]                img_wr_data,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   output logic                       cfg_err,
   output logic [15:0]                pe_weight_val,
   output logic                       pe_weight_en,
   output logic [15:0]                pe_image_val,
   output logic                       pe_image_en,
   output logic [15:0]                pe_psum_in,
   input  logic [15:0]                pe_psum_out,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [15:0]                out_data
);

   localparam int unsigned KW = $clog2(K_MAX+1);
   localparam int unsigned KA = $clog2(K_MAX);
   localparam int unsigned NW = $clog2(N_MAX+1);
   localparam int unsigned NA = $clog2(N_MAX);

   pe_seq_state_t state;
   logic [KW-1:0] k, kcfg;
   logic [NW-1:0] ncfg;
   logic [NA-1:0] i;
   q78_t          acc;

   logic [15:0]   wbuf_rd, ibuf_rd;
   logic          cfg_ok, last_out, tap_found;
   logic [KW-1:0] scan_from, k_lim, nxt_tap;
   logic [KA-1:0] w_rd_addr;
   logic [NA-1:0] i_rd_addr;
   logic          w_we, i_we;

   assign busy = (state != IDLE);
   assign w_we = wgt_wr_en && (state == IDLE);
   assign i_we = img_wr_en && (state == IDLE);

   assign cfg_ok = (cfg_k != '0) && (cfg_k <= KW'(K_MAX)) &&
                   (NW'(cfg_k) <= cfg_n) && (cfg_n <= NW'(N_MAX));
   assign last_out = (NW'(i) == (ncfg - NW'(kcfg)));

   // Next tap to load: from IDLE/EMIT scan starts at 0, from MAC at k+1.
   assign scan_from = (state == MAC) ? (k + KW'(1)) : '0;
   assign k_lim     = (state == IDLE) ? cfg_k : kcfg;

`ifdef PE_TAP_SEQ_SKIP_ZERO_EN
   logic [K_MAX-1:0] wnz;

   always_ff @(posedge clk) begin
      if (w_we) wnz[wgt_wr_addr] <= (wgt_wr_data != '0);
   end

   always_comb begin
      nxt_tap   = k_lim;
      tap_found = 1'b0;
      for (int unsigned j = 0; j < K_MAX; j++) begin
         if (!tap_found && (KW'(j) >= scan_from) && (KW'(j) < k_lim) && wnz[j]) begin
            nxt_tap   = KW'(j);
            tap_found = 1'b1;
         end
      end
   end
`else
   always_comb begin
      nxt_tap   = scan_from;
      tap_found = (scan_from < k_lim);
   end
`endif

   assign w_rd_addr = KA'(nxt_tap);
   assign i_rd_addr = i + NA'(k);

   pe_row_buf #(.DEPTH(K_MAX)) u_wbuf (
      .clk     (clk),
      .wr_en   (w_we),
      .wr_addr (wgt_wr_addr),
      .wr_data (wgt_wr_data),
      .rd_addr (w_rd_addr),
      .rd_data (wbuf_rd)
   );

   pe_row_buf #(.DEPTH(N_MAX)) u_ibuf (
      .clk     (clk),
      .wr_en   (i_we),
      .wr_addr (img_wr_addr),
      .wr_data (img_wr_data),
      .rd_addr (i_rd_addr),
      .rd_data (ibuf_rd)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         k             <= '0;
         kcfg          <= '0;
         ncfg          <= '0;
         i             <= '0;
         acc           <= '0;
         done          <= 1'b0;
         cfg_err       <= 1'b0;
         pe_weight_en  <= 1'b0;
         pe_weight_val <= '0;
         pe_image_en   <= 1'b0;
         pe_image_val  <= '0;
         pe_psum_in    <= '0;
         out_valid     <= 1'b0;
         out_data      <= '0;
      end else begin
         done          <= 1'b0;
         cfg_err       <= 1'b0;
         pe_weight_en  <= 1'b0;
         pe_weight_val <= '0;
         pe_image_en   <= 1'b0;
         pe_image_val  <= '0;
         pe_psum_in    <= '0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (cfg_ok) begin
                     kcfg <= cfg_k;
                     ncfg <= cfg_n;
                     i    <= '0;
                     acc  <= '0;
                     if (tap_found) begin
                        state         <= LOAD_W;
                        k             <= nxt_tap;
                        pe_weight_en  <= 1'b1;
                        pe_weight_val <= wbuf_rd;
                     end else begin
                        state     <= EMIT;
                        k         <= '0;
                        out_valid <= 1'b1;
                        out_data  <= '0;
                     end
                  end else begin
                     state   <= DONE;
                     done    <= 1'b1;
                     cfg_err <= 1'b1;
                  end
               end
            end
            LOAD_W: begin
               state        <= MAC;
               pe_image_en  <= 1'b1;
               pe_image_val <= ibuf_rd;
               pe_psum_in   <= acc;
            end
            MAC: begin
               acc <= pe_psum_out;
               if (tap_found) begin
                  state         <= LOAD_W;
                  k             <= nxt_tap;
                  pe_weight_en  <= 1'b1;
                  pe_weight_val <= wbuf_rd;
               end else begin
                  // PE result goes straight to the stream register alongside acc.
                  state     <= EMIT;
                  out_valid <= 1'b1;
                  out_data  <= pe_psum_out;
               end
            end
            EMIT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_data  <= '0;
                  if (last_out) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     i   <= i + NA'(1);
                     acc <= '0;
                     if (tap_found) begin
                        state         <= LOAD_W;
                        k             <= nxt_tap;
                        pe_weight_en  <= 1'b1;
                        pe_weight_val <= wbuf_rd;
                     end else begin
                        out_valid <= 1'b1;
                     end
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
